// File: rtl/set_bit_scanner_pkg.sv
// set_bit_scanner_pkg
//   Shared types and helpers for the set-bit scanner: the scanner FSM state
//   encoding, the position-width derivation and the single-bit detector that
//   drives out_last.
package set_bit_scanner_pkg;

  // Scanner control states: waiting for a vector, or walking its set bits.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Widest vector the helpers below support; callers zero-extend into it.
  localparam int unsigned MAX_W = 64;

  // Position width for a W-bit vector; never narrower than one bit.
  function automatic int unsigned pos_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // True when at most one bit is set. Zero-extension keeps the popcount, so
  // callers can pass any vector up to MAX_W bits.
  function automatic logic onehot_or_zero(input logic [MAX_W-1:0] vec);
    return (vec & (vec - MAX_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/set_bit_scanner_first_one.sv
// first_one_find
//   Combinational find-first-one over a [0:W-1] vector; index 0 has the
//   highest priority, so the lowest set index wins.
//   Ports:
//     vec   in   W    [0:W-1] vector to search
//     valid out  1    at least one bit of vec is set
//     pos   out  PW   index of the lowest set bit (0 when valid=0)
module first_one_find
  import set_bit_scanner_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned PW = pos_width(W)
) (
  input  logic [0:W-1]  vec,
  output logic          valid,
  output logic [0:PW-1] pos
);

  // Walk from the highest index down so the lowest set index is written last.
  always_comb begin
    valid = |vec;
    pos   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos = PW'(i);
      end
    end
  end

endmodule

// File: rtl/set_bit_scanner.sv
// set_bit_scanner
//   Accepts a W-bit request vector and serialises it into one handshake per
//   set bit, lowest index first, clearing each bit once it is consumed.
//   All-zero vectors are accepted, dropped and flagged on zero_drop.
//   Ports:
//     clk        in   1    clock, rising edge
//     rst        in   1    asynchronous active-high reset
//     in_valid   in   1    in_vec valid
//     in_ready   out  1    scanner idle and able to take a vector
//     in_vec     in   W    [0:W-1] request vector, index 0 = highest priority
//     out_valid  out  1    out_pos / out_last valid
//     out_ready  in   1    consumer takes the current position
//     out_pos    out  PW   index of first set bit still pending
//     out_last   out  1    current position is the final one of the vector
//     zero_drop  out  1    one-cycle pulse: an all-zero vector was discarded
module set_bit_scanner
  import set_bit_scanner_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned PW = pos_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:W-1]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:PW-1] out_pos,
  output logic          out_last,
  output logic          zero_drop
);

  scan_state_t   state;
  scan_state_t   state_d;
  logic [0:W-1]  rem;
  logic [0:W-1]  rem_d;
  logic          zero_drop_d;
  logic          ff_valid;
  logic [0:PW-1] ff_pos;

  // Priority pick over the bits not yet emitted.
  first_one_find #(
    .W (W)
  ) u_first_one (
    .vec   (rem),
    .valid (ff_valid),
    .pos   (ff_pos)
  );

  assign out_pos  = ff_pos;
  assign out_last = ff_valid && onehot_or_zero(MAX_W'(rem));

  // State, pending-bit register and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      zero_drop <= 1'b0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      zero_drop <= zero_drop_d;
    end
  end

  // Next-state and handshake decode. in_ready and out_valid are pure decodes
  // of the state flop, so a vector is never accepted in the same cycle as the
  // final output handshake.
  always_comb begin
    state_d     = state;
    rem_d       = rem;
    zero_drop_d = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (|in_vec) begin
            rem_d   = in_vec;
            state_d = SCAN;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rem_d[ff_pos] = 1'b0;
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  // SCAN always holds at least one pending bit; an empty SCAN would emit garbage.
  a_scan_nonempty: assert property (@(posedge clk) disable iff (rst)
    !(state == SCAN && rem == '0));
`endif

endmodule

// File: tb/tb_set_bit_scanner.sv
// tb_set_bit_scanner
//   Directed bench for set_bit_scanner with W=8. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_set_bit_scanner;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [0:W-1]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [0:PW-1] out_pos;
  logic          out_last;
  logic          zero_drop;

  int checks;
  int failures;

  set_bit_scanner #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .zero_drop (zero_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input int p, input logic l);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, ".out_pos"},  32'(out_pos),  32'(p));
      chk({tag, ".out_last"}, 32'(out_last), 32'(l));
    end
  endtask

  initial begin
    int exp_pos;
    bit done;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.zero_drop", 32'(zero_drop), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: bits 2,5,7 with out_ready held high
    in_valid  = 1'b1;
    in_vec    = 8'b0010_0101;
    out_ready = 1'b1;
    chk("t1.in_ready_pre", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    chk("t1.in_ready_busy", 32'(in_ready), 32'd0);
    chk_out("t1.p2", 1'b1, 2, 1'b0);
    tick();
    chk_out("t1.p5", 1'b1, 5, 1'b0);
    tick();
    chk_out("t1.p7", 1'b1, 7, 1'b1);
    tick();
    chk_out("t1.end", 1'b0, 0, 1'b0);
    chk("t1.in_ready_back", 32'(in_ready), 32'd1);

    // 2: all-zero vector is dropped with a one-cycle pulse
    in_valid = 1'b1;
    in_vec   = 8'b0000_0000;
    tick();
    in_valid = 1'b0;
    chk("t2.zero_drop", 32'(zero_drop), 32'd1);
    chk_out("t2.nout", 1'b0, 0, 1'b0);
    chk("t2.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t2.zero_drop_clr", 32'(zero_drop), 32'd0);
    chk_out("t2.nout2", 1'b0, 0, 1'b0);

    // 3: bits 0,7 with a three-cycle stall on position 0
    in_valid  = 1'b1;
    in_vec    = 8'b1000_0001;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("t3.stall%0d", k), 1'b1, 0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    chk_out("t3.p0", 1'b1, 0, 1'b0);
    tick();
    chk_out("t3.p7", 1'b1, 7, 1'b1);
    tick();
    chk_out("t3.end", 1'b0, 0, 1'b0);

    // 4: all ones with random out_ready
    in_valid = 1'b1;
    in_vec   = 8'hFF;
    tick();
    in_valid = 1'b0;
    exp_pos  = 0;
    done     = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      out_ready = 1'($urandom);
      chk_out($sformatf("t4.c%0d", k), 1'b1, exp_pos, 1'(exp_pos == 7));
      if (out_valid && out_ready) begin
        exp_pos++;
        if (exp_pos == 8) done = 1'b1;
      end
      tick();
    end
    chk("t4.count", 32'(exp_pos), 32'd8);
    out_ready = 1'b1;
    chk_out("t4.end", 1'b0, 0, 1'b0);

    // 5: reset after first output of bits 1,2
    in_valid = 1'b1;
    in_vec   = 8'b0110_0000;
    tick();
    in_valid = 1'b0;
    chk_out("t5.p1", 1'b1, 1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.async_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = 8'b0000_0001;
    tick();
    in_valid = 1'b0;
    chk_out("t5.p7", 1'b1, 7, 1'b1);
    tick();
    chk_out("t5.end", 1'b0, 0, 1'b0);

    // 6: in_valid held during SCAN with a new vector waiting
    in_valid = 1'b1;
    in_vec   = 8'b1100_0000;
    tick();
    in_vec = 8'b0001_0000;
    chk("t6.in_ready_busy", 32'(in_ready), 32'd0);
    chk_out("t6.p0", 1'b1, 0, 1'b0);
    tick();
    chk_out("t6.p1", 1'b1, 1, 1'b1);
    tick();
    chk_out("t6.bubble", 1'b0, 0, 1'b0);
    chk("t6.in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("t6.p3", 1'b1, 3, 1'b1);
    tick();
    chk_out("t6.end", 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
